// File: rtl/warp_arbiter_if.sv
// Handshake bundle between per-warp fetchers, the shared execute slot and warp_arbiter.
interface warp_arbiter_if #(
  parameter int NUM_WARPS    = 4,
  parameter int WARP_ID_BITS = $clog2(NUM_WARPS)
);
  logic [NUM_WARPS-1:0]    warp_reset;
  logic [NUM_WARPS-1:0]    warp_start;
  logic [NUM_WARPS-1:0]    warp_req;
  logic                    exec_done;
  logic                    exec_ret;
  logic [NUM_WARPS-1:0]    grant;
  logic                    grant_valid;
  logic [WARP_ID_BITS-1:0] warp_select;
  logic [NUM_WARPS-1:0]    warp_done;
  logic                    proto_err;

  modport master (
    output warp_reset, warp_start, warp_req, exec_done, exec_ret,
    input  grant, grant_valid, warp_select, warp_done, proto_err
  );

  modport slave (
    input  warp_reset, warp_start, warp_req, exec_done, exec_ret,
    output grant, grant_valid, warp_select, warp_done, proto_err
  );
endinterface

// File: rtl/warp_arbiter.sv
// Round-robin arbiter time-sharing one execute slot among NUM_WARPS warps, tracking per-warp lifecycle.
// Optional hold timeout is built only when WARP_ARB_TIMEOUT_EN is defined.
module warp_arbiter #(
  parameter int NUM_WARPS    = 4,
  parameter int WARP_ID_BITS = $clog2(NUM_WARPS),
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  warp_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_READY = 2'd1,
    W_RUN   = 2'd2,
    W_DONE  = 2'd3
  } warp_status_e;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  localparam logic [WARP_ID_BITS-1:0] LAST_ID = WARP_ID_BITS'(NUM_WARPS - 1);

  if (NUM_WARPS < 2) begin : g_bad_num_warps
    $error("warp_arbiter: NUM_WARPS must be at least 2");
  end
  if (HOLD_TIMEOUT < 1) begin : g_bad_hold_timeout
    $error("warp_arbiter: HOLD_TIMEOUT must be at least 1");
  end

  arb_state_e              state_q, state_d;
  logic [WARP_ID_BITS-1:0] rr_q, rr_d;
  logic [WARP_ID_BITS-1:0] sel_q, sel_d;
  logic [NUM_WARPS-1:0]    grant_q, grant_d;
  logic                    grant_valid_q, grant_valid_d;
  logic [NUM_WARPS-1:0]    done_q, done_d;
  logic                    perr_q, perr_d;
  warp_status_e            status_q [NUM_WARPS];
  warp_status_e            status_d [NUM_WARPS];

  logic [NUM_WARPS-1:0]    eligible_s;
  logic                    found_s;
  logic [WARP_ID_BITS-1:0] pick_s;
  logic                    timeout_s;
  logic                    retire_s;
  logic                    to_fire_s;

`ifdef WARP_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(HOLD_TIMEOUT + 1) > 8) ? $clog2(HOLD_TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  // Hold-age counter: zero in ARB so every HOLD entry starts from zero.
  always_comb begin
    hold_cnt_d = (state_q == ST_HOLD) ? hold_cnt_q + 1'b1 : '0;
    timeout_s  = (state_q == ST_HOLD) && (hold_cnt_q == CNT_W'(HOLD_TIMEOUT - 1));
  end

  // Hold-age counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Eligibility and rotating search; scanning downward leaves the first match at or after rr_q.
  always_comb begin
    int idx_v;
    idx_v   = 0;
    found_s = 1'b0;
    pick_s  = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      eligible_s[w] = bus.warp_req[w] && !bus.warp_reset[w] &&
                      ((status_q[w] == W_READY) || (status_q[w] == W_RUN));
    end
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      idx_v   = (int'(rr_q) + i >= NUM_WARPS) ? int'(rr_q) + i - NUM_WARPS : int'(rr_q) + i;
      pick_s  = eligible_s[idx_v] ? WARP_ID_BITS'(idx_v) : pick_s;
      found_s = found_s | eligible_s[idx_v];
    end
  end

  // Arbitration FSM, per-warp lifecycle and sticky protocol error.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    perr_d    = perr_q;
    status_d  = status_q;
    retire_s  = 1'b0;
    to_fire_s = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (found_s) begin
          state_d = ST_HOLD;
          sel_d   = pick_s;
          grant_d = NUM_WARPS'(1) << pick_s;
        end else begin
          grant_d = '0;
        end
      end
      ST_HOLD: begin
        // Resetting the granted warp wins over a coincident retire and leaves rr_q alone.
        if (bus.warp_reset[sel_q]) begin
          state_d = ST_ARB;
          grant_d = '0;
        end else if (bus.exec_done || timeout_s) begin
          state_d   = ST_ARB;
          grant_d   = '0;
          rr_d      = (sel_q == LAST_ID) ? '0 : sel_q + 1'b1;
          retire_s  = bus.exec_done & bus.exec_ret;
          to_fire_s = !bus.exec_done;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_ARB;
        grant_d = '0;
      end
    endcase

    perr_d = perr_q | (bus.exec_done && (state_q == ST_ARB)) |
             (bus.exec_ret && !bus.exec_done) | to_fire_s;

    for (int w = 0; w < NUM_WARPS; w++) begin
      if (bus.warp_reset[w]) begin
        status_d[w] = W_IDLE;
      end else begin
        case (status_q[w])
          W_IDLE:  status_d[w] = bus.warp_start[w] ? W_READY : W_IDLE;
          W_READY: status_d[w] = ((state_q == ST_ARB) && found_s && (pick_s == WARP_ID_BITS'(w)))
                                 ? W_RUN : W_READY;
          W_RUN:   status_d[w] = (retire_s && (sel_q == WARP_ID_BITS'(w))) ? W_DONE : W_RUN;
          W_DONE:  status_d[w] = W_DONE;
          default: status_d[w] = W_IDLE;
        endcase
      end
      done_d[w] = (status_d[w] == W_DONE);
    end

    grant_valid_d = |grant_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_ARB;
      rr_q          <= '0;
      sel_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      done_q        <= '0;
      perr_q        <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        status_q[w] <= W_IDLE;
      end
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      sel_q         <= sel_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      done_q        <= done_d;
      perr_q        <= perr_d;
      for (int w = 0; w < NUM_WARPS; w++) begin
        status_q[w] <= status_d[w];
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.warp_select = sel_q;
  assign bus.warp_done   = done_q;
  assign bus.proto_err   = perr_q;

endmodule

// File: tb/tb_warp_arbiter.sv
// Bench for warp_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// A 4-warp instance carries most scenarios; a 3-warp instance covers non-power-of-2 wrap.
module tb_warp_arbiter;
  localparam int N4     = 4;
  localparam int HOLD_T = 10;
  localparam int M_IDLE = 0, M_READY = 1, M_RUN = 2, M_DONE = 3;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  // model of the 4-warp instance: status per warp, current holder (-1 = none), pointer
  int   m_st [N4];
  int   m_hold;
  int   m_rr;
  int   m_sel;
  int   m_age;
  logic m_perr;

  warp_arbiter_if #(.NUM_WARPS(4)) b4 ();
  warp_arbiter_if #(.NUM_WARPS(3)) b3 ();

  warp_arbiter #(.NUM_WARPS(4), .HOLD_TIMEOUT(HOLD_T)) dut4 (.clk(clk), .reset_n(reset_n), .bus(b4.slave));
  warp_arbiter #(.NUM_WARPS(3), .HOLD_TIMEOUT(HOLD_T)) dut3 (.clk(clk), .reset_n(reset_n), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int w = 0; w < N4; w++) m_st[w] = M_IDLE;
    m_hold = -1; m_rr = 0; m_sel = 0; m_age = 0; m_perr = 1'b0;
  endtask

  // One clock of the lifecycle/round-robin rules, applied to the inputs present at the edge.
  task automatic model_update();
    logic [3:0] wr, ws, rq;
    logic ed, er;
    int nh, w;
    wr = b4.warp_reset; ws = b4.warp_start; rq = b4.warp_req;
    ed = b4.exec_done; er = b4.exec_ret;
    nh = m_hold;
    if ((ed && m_hold < 0) || (er && !ed)) m_perr = 1'b1;
    if (m_hold >= 0) begin
      if (wr[m_hold]) nh = -1;
      else if (ed) begin
        if (er) m_st[m_hold] = M_DONE;
        m_rr = (m_hold + 1) % N4;
        nh = -1;
      end
`ifdef WARP_ARB_TIMEOUT_EN
      else if (m_age == HOLD_T - 1) begin
        m_rr = (m_hold + 1) % N4;
        nh = -1;
        m_perr = 1'b1;
      end else m_age++;
`endif
    end else begin
      for (int k = 0; k < N4; k++) begin
        w = (m_rr + k) % N4;
        if (nh < 0 && rq[w] && !wr[w] && (m_st[w] == M_READY || m_st[w] == M_RUN)) begin
          nh = w; m_sel = w; m_st[w] = M_RUN; m_age = 0;
        end
      end
    end
    for (int i = 0; i < N4; i++) begin
      if (wr[i]) m_st[i] = M_IDLE;
      else if (m_st[i] == M_IDLE && ws[i]) m_st[i] = M_READY;
    end
    m_hold = nh;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    b4.warp_reset = '0; b4.warp_start = '0; b4.warp_req = '0; b4.exec_done = 1'b0; b4.exec_ret = 1'b0;
    b3.warp_reset = '0; b3.warp_start = '0; b3.warp_req = '0; b3.exec_done = 1'b0; b3.exec_ret = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (b4.grant !== 4'b0000 || b4.grant_valid !== 1'b0) begin n_errors++; $display("FAIL reset_grant actual=%b/%b required=0000/0", b4.grant, b4.grant_valid); end
    n_checks++; if (b4.warp_done !== 4'b0000 || b4.proto_err !== 1'b0 || b4.warp_select !== 2'd0) begin n_errors++; $display("FAIL reset_flags actual done=%b perr=%b sel=%0d required 0", b4.warp_done, b4.proto_err, b4.warp_select); end
    b4.warp_start = 4'b0100; b4.warp_req = 4'b0100;
    step();
    b4.warp_start = 4'b0000;
    step();
    n_checks++; if (b4.grant !== 4'b0100) begin n_errors++; $display("FAIL reset_pre_grant actual=%b required=0100", b4.grant); end
    reset_n = 1'b0;
    #2;
    n_checks++; if (b4.grant !== 4'b0000 || b4.grant_valid !== 1'b0 || b4.warp_select !== 2'd0 || b4.warp_done !== 4'b0000 || b4.proto_err !== 1'b0) begin n_errors++; $display("FAIL reset_async actual grant=%b gv=%b sel=%0d done=%b perr=%b required all 0", b4.grant, b4.grant_valid, b4.warp_select, b4.warp_done, b4.proto_err); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    step();
    step();
    n_checks++; if (b4.grant !== 4'b0000) begin n_errors++; $display("FAIL reset_idle_no_grant actual=%b required=0000", b4.grant); end
    b4.warp_req = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    b4.warp_start = 4'hF; b4.warp_req = 4'hF;
    step();
    b4.warp_start = 4'h0;
    step();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      n_checks++; if (b4.grant !== exp_g || b4.warp_select !== 2'(k % 4)) begin n_errors++; $display("FAIL rr_grant%0d actual=%b sel=%0d required=%b sel=%0d", k, b4.grant, b4.warp_select, exp_g, k % 4); end
      step();
      n_checks++; if (b4.grant !== exp_g) begin n_errors++; $display("FAIL rr_hold%0d actual=%b required=%b", k, b4.grant, exp_g); end
      b4.exec_done = 1'b1;
      step();
      b4.exec_done = 1'b0;
      n_checks++; if (b4.grant !== 4'b0000 || b4.grant_valid !== 1'b0) begin n_errors++; $display("FAIL rr_bubble%0d actual=%b required=0000", k, b4.grant); end
      if (k < 4) step();
    end
    b4.warp_req = 4'h0;
  endtask

  task automatic test_done();
    b4.warp_req = 4'b0100;
    step();
    n_checks++; if (b4.grant !== 4'b0100 || b4.warp_select !== 2'd2) begin n_errors++; $display("FAIL done_grant actual=%b required=0100", b4.grant); end
    b4.exec_done = 1'b1; b4.exec_ret = 1'b1;
    step();
    b4.exec_done = 1'b0; b4.exec_ret = 1'b0;
    n_checks++; if (b4.warp_done !== 4'b0100) begin n_errors++; $display("FAIL done_flag actual=%b required=0100", b4.warp_done); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (b4.grant !== 4'b0000) begin n_errors++; $display("FAIL done_no_regrant%0d actual=%b required=0000", i, b4.grant); end
    end
    b4.warp_reset = 4'b0100;
    step();
    b4.warp_reset = 4'b0000; b4.warp_req = 4'b0000;
    n_checks++; if (b4.warp_done !== 4'b0000 || b4.proto_err !== 1'b0) begin n_errors++; $display("FAIL done_clear actual done=%b perr=%b required 0000/0", b4.warp_done, b4.proto_err); end
  endtask

  task automatic test_mid_reset();
    b4.warp_start = 4'b0100; b4.warp_req = 4'b0001;
    step();
    b4.warp_start = 4'b0000;
    n_checks++; if (b4.grant !== 4'b0001) begin n_errors++; $display("FAIL mid_w0_grant actual=%b required=0001", b4.grant); end
    b4.exec_done = 1'b1;
    step();
    b4.exec_done = 1'b0; b4.warp_req = 4'b0010;
    step();
    n_checks++; if (b4.grant !== 4'b0010) begin n_errors++; $display("FAIL mid_w1_grant actual=%b required=0010", b4.grant); end
    b4.warp_reset = 4'b0010; b4.exec_done = 1'b1;
    step();
    b4.warp_reset = 4'b0000; b4.exec_done = 1'b0;
    n_checks++; if (b4.grant !== 4'b0000 || b4.warp_done !== 4'b0000 || b4.proto_err !== 1'b0) begin n_errors++; $display("FAIL mid_release actual grant=%b done=%b perr=%b required 0000/0000/0", b4.grant, b4.warp_done, b4.proto_err); end
    step();
    n_checks++; if (b4.grant !== 4'b0000) begin n_errors++; $display("FAIL mid_w1_idle actual=%b required=0000", b4.grant); end
    b4.warp_start = 4'b0010;
    step();
    b4.warp_start = 4'b0000; b4.warp_req = 4'hF;
    step();
    n_checks++; if (b4.grant !== 4'b0010) begin n_errors++; $display("FAIL mid_rr_kept actual=%b required=0010", b4.grant); end
    b4.exec_done = 1'b1;
    step();
    b4.exec_done = 1'b0; b4.warp_req = 4'h0;
  endtask

  task automatic test_wrap3();
    logic [2:0] exp3 [4];
    exp3[0] = 3'b100; exp3[1] = 3'b001; exp3[2] = 3'b100; exp3[3] = 3'b001;
    do_reset();
    b3.warp_start = 3'b111; b3.warp_req = 3'b010;
    step();
    b3.warp_start = 3'b000;
    step();
    n_checks++; if (b3.grant !== 3'b010) begin n_errors++; $display("FAIL wrap3_w1 actual=%b required=010", b3.grant); end
    b3.exec_done = 1'b1;
    step();
    b3.exec_done = 1'b0; b3.warp_req = 3'b101;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if (b3.grant !== exp3[k]) begin n_errors++; $display("FAIL wrap3_seq%0d actual=%b required=%b", k, b3.grant, exp3[k]); end
      b3.exec_done = 1'b1;
      step();
      b3.exec_done = 1'b0;
    end
    n_checks++; if (b3.proto_err !== 1'b0 || b3.warp_select !== 2'd0) begin n_errors++; $display("FAIL wrap3_end actual perr=%b sel=%0d required 0/0", b3.proto_err, b3.warp_select); end
    b3.warp_req = 3'b000;
  endtask

  task automatic test_protocol();
    do_reset();
    b4.exec_ret = 1'b1;
    step();
    b4.exec_ret = 1'b0;
    n_checks++; if (b4.proto_err !== 1'b1) begin n_errors++; $display("FAIL proto_ret_alone actual=%b required=1", b4.proto_err); end
    do_reset();
    n_checks++; if (b4.proto_err !== 1'b0) begin n_errors++; $display("FAIL proto_after_reset actual=%b required=0", b4.proto_err); end
    b4.exec_done = 1'b1;
    step();
    b4.exec_done = 1'b0;
    repeat (3) step();
    n_checks++; if (b4.proto_err !== 1'b1 || b4.grant !== 4'b0000) begin n_errors++; $display("FAIL proto_sticky actual perr=%b grant=%b required 1/0000", b4.proto_err, b4.grant); end
  endtask

`ifdef WARP_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    b4.warp_start = 4'hF; b4.warp_req = 4'hF;
    step();
    b4.warp_start = 4'h0;
    step();
    for (int i = 0; i < HOLD_T; i++) begin
      n_checks++; if (b4.grant !== 4'b0001) begin n_errors++; $display("FAIL timeout_hold%0d actual=%b required=0001", i, b4.grant); end
      step();
    end
    n_checks++; if (b4.grant !== 4'b0000 || b4.proto_err !== 1'b1) begin n_errors++; $display("FAIL timeout_release actual grant=%b perr=%b required 0000/1", b4.grant, b4.proto_err); end
    step();
    n_checks++; if (b4.grant !== 4'b0010) begin n_errors++; $display("FAIL timeout_next actual=%b required=0010", b4.grant); end
    b4.warp_req = 4'h0;
  endtask
`endif

  task automatic test_random();
    logic [3:0] st, rs, exp_g, exp_d;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int w = 0; w < N4; w++) begin
        st[w] = ($urandom_range(0, 99) < 15);
        rs[w] = ($urandom_range(0, 99) < 3);
      end
      b4.warp_start = st; b4.warp_reset = rs;
      b4.warp_req   = 4'($urandom_range(0, 15));
      b4.exec_done  = (m_hold >= 0) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 2);
      b4.exec_ret   = b4.exec_done ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 1);
      step();
      exp_g = (m_hold >= 0) ? (4'b0001 << m_hold) : 4'b0000;
      for (int w = 0; w < N4; w++) exp_d[w] = (m_st[w] == M_DONE);
      n_checks++; if (b4.grant !== exp_g || b4.grant_valid !== (m_hold >= 0)) begin n_errors++; $display("FAIL rand_grant c=%0d actual=%b/%b required=%b", c, b4.grant, b4.grant_valid, exp_g); end
      n_checks++; if (b4.warp_select !== 2'(m_sel)) begin n_errors++; $display("FAIL rand_sel c=%0d actual=%0d required=%0d", c, b4.warp_select, m_sel); end
      n_checks++; if (b4.warp_done !== exp_d) begin n_errors++; $display("FAIL rand_done c=%0d actual=%b required=%b", c, b4.warp_done, exp_d); end
      n_checks++; if (b4.proto_err !== m_perr) begin n_errors++; $display("FAIL rand_perr c=%0d actual=%b required=%b", c, b4.proto_err, m_perr); end
    end
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_round_robin();
    test_done();
    test_mid_reset();
    test_wrap3();
    test_protocol();
`ifdef WARP_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
